// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter in front of one shared enabled register, with an
// optional per-requester burst lock that is bounded by MAX_LOCK cycles.
module shared_reg_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_LOCK = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req,
  input  logic [N-1:0]           lock,
  input  logic [N*WIDTH-1:0]     din,
  output logic [N-1:0]           gnt,
  output logic [WIDTH-1:0]       q,
  output logic                   wr_en,
  output logic [$clog2(N)-1:0]   owner,
  output logic                   locked,
  output logic                   lock_timeout
);

  localparam int unsigned OW = $clog2(N);
  localparam int unsigned CW = $clog2(MAX_LOCK + 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t          state, nxt_state;
  logic [OW-1:0]   ptr, nxt_ptr;
  logic [CW-1:0]   lock_cnt, nxt_cnt;
  logic [N-1:0]    nxt_gnt;
  logic [WIDTH-1:0] nxt_q;
  logic            nxt_wr_en;
  logic [OW-1:0]   nxt_owner;
  logic            nxt_timeout;

  logic            found;
  logic [OW-1:0]   win;
  logic [OW:0]     idx;
  logic [OW:0]     owner_inc;
  logic [OW:0]     win_inc;

  // Round-robin search starting at ptr; idx is one bit wider so the
  // wrap-around can be done with a single conditional subtract.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = {1'b0, ptr} + (OW+1)'(i);
      if (idx >= (OW+1)'(N)) idx = idx - (OW+1)'(N);
      if (!found && req[idx[OW-1:0]]) begin
        found = 1'b1;
        win   = idx[OW-1:0];
      end
    end
  end

  always_comb begin
    win_inc = {1'b0, win} + 1'b1;
    if (win_inc == (OW+1)'(N)) win_inc = '0;
    owner_inc = {1'b0, owner} + 1'b1;
    if (owner_inc == (OW+1)'(N)) owner_inc = '0;
  end

  always_comb begin
    nxt_state   = state;
    nxt_ptr     = ptr;
    nxt_cnt     = lock_cnt;
    nxt_gnt     = '0;
    nxt_q       = q;
    nxt_wr_en   = 1'b0;
    nxt_owner   = owner;
    nxt_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          nxt_q        = din[win*WIDTH +: WIDTH];
          nxt_gnt[win] = 1'b1;
          nxt_wr_en    = 1'b1;
          nxt_owner    = win;
          nxt_ptr      = win_inc[OW-1:0];
          if (lock[win]) begin
            nxt_state = LOCKED;
            nxt_cnt   = '0;
          end
        end
      end
      LOCKED: begin
        nxt_cnt = lock_cnt + CW'(1);
        if (req[owner]) begin
          nxt_q          = din[owner*WIDTH +: WIDTH];
          nxt_gnt[owner] = 1'b1;
          nxt_wr_en      = 1'b1;
        end
        // Both exits still let a same-cycle owner write through above.
        if (lock_cnt == CW'(MAX_LOCK - 1)) nxt_timeout = 1'b1;
        if (!lock[owner] || nxt_timeout) begin
          nxt_state = IDLE;
          nxt_ptr   = owner_inc[OW-1:0];
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      lock_cnt     <= '0;
      gnt          <= '0;
      q            <= '0;
      wr_en        <= 1'b0;
      owner        <= '0;
      lock_timeout <= 1'b0;
    end else begin
      state        <= nxt_state;
      ptr          <= nxt_ptr;
      lock_cnt     <= nxt_cnt;
      gnt          <= nxt_gnt;
      q            <= nxt_q;
      wr_en        <= nxt_wr_en;
      owner        <= nxt_owner;
      lock_timeout <= nxt_timeout;
    end
  end

  assign locked = (state == LOCKED);

endmodule
